// File: rtl/gmii_tx_arbiter.sv
// Packet-level round-robin arbiter that shares one GMII transmit port between two
// FWFT 9-bit packet FIFOs, with inter-frame gap, length truncation and underrun signalling.
module gmii_tx_arbiter #(
  parameter int IFG_CYCLES  = 12,
  parameter int MAX_PKT_LEN = 1536
) (
  input  logic        clk_125m,
  input  logic        rst,
  input  logic        tx_enable,
  input  logic        empty_0,
  input  logic [8:0]  dout_0,
  output logic        rden_0,
  input  logic        empty_1,
  input  logic [8:0]  dout_1,
  output logic        rden_1,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [31:0] cnt_pkt_0,
  output logic [31:0] cnt_pkt_1,
  output logic [15:0] cnt_trunc,
  output logic [15:0] cnt_underrun
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, IFG} state_t;

  localparam int              BC_W     = 12;
  localparam logic [BC_W-1:0] MAX_LEN  = BC_W'(MAX_PKT_LEN);
  localparam logic [7:0]      IFG_LAST = 8'(IFG_CYCLES - 1);

  state_t          state_q;
  logic            grant_q;
  logic            last_grant_q;
  logic [BC_W-1:0] byte_cnt_q;
  logic [BC_W-1:0] byte_cnt_d;
  logic [7:0]      ifg_cnt_q;
  logic [7:0]      txd_q;
  logic            tx_en_q;
  logic            tx_er_q;
  logic [31:0]     cnt_pkt_0_q;
  logic [31:0]     cnt_pkt_1_q;
  logic [15:0]     cnt_trunc_q;
  logic [15:0]     cnt_underrun_q;

  logic            sel_empty;
  logic [8:0]      sel_word;
  logic            xfer_phase;
  logic            pop;
  logic            grant_d;
  logic            req_any;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Head word of the granted FIFO; pops are combinational so FWFT data is consumed in-cycle.
  assign sel_empty  = grant_q ? empty_1 : empty_0;
  assign sel_word   = grant_q ? dout_1  : dout_0;
  assign xfer_phase = (state_q == STREAM) || (state_q == DRAIN);
  assign pop        = !rst && xfer_phase && !sel_empty;
  assign rden_0     = pop && !grant_q;
  assign rden_1     = pop &&  grant_q;

  assign byte_cnt_d = byte_cnt_q + BC_W'(1);
  assign req_any    = !empty_0 || !empty_1;
  // On a tie the port that did not go last wins; otherwise whichever port has data.
  assign grant_d    = (!empty_0 && !empty_1) ? !last_grant_q : empty_0;

  always_ff @(posedge clk_125m) begin
    if (rst) begin
      state_q        <= IDLE;
      grant_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      byte_cnt_q     <= '0;
      ifg_cnt_q      <= '0;
      txd_q          <= '0;
      tx_en_q        <= 1'b0;
      tx_er_q        <= 1'b0;
      cnt_pkt_0_q    <= '0;
      cnt_pkt_1_q    <= '0;
      cnt_trunc_q    <= '0;
      cnt_underrun_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_en_q <= 1'b0;
          tx_er_q <= 1'b0;
          if (tx_enable && req_any) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            byte_cnt_q   <= '0;
            state_q      <= STREAM;
          end
        end

        STREAM: begin
          if (sel_empty) begin
            txd_q          <= '0;
            tx_en_q        <= 1'b1;
            tx_er_q        <= 1'b1;
            cnt_underrun_q <= sat_inc16(cnt_underrun_q);
          end else if (sel_word[8]) begin
            txd_q      <= sel_word[7:0];
            tx_en_q    <= 1'b1;
            tx_er_q    <= 1'b0;
            byte_cnt_q <= byte_cnt_d;
            // The byte reaching the limit is still sent; the rest of the packet is discarded.
            if (byte_cnt_d == MAX_LEN) begin
              cnt_trunc_q <= sat_inc16(cnt_trunc_q);
              state_q     <= DRAIN;
            end
          end else begin
            tx_en_q <= 1'b0;
            tx_er_q <= 1'b0;
            if (grant_q) cnt_pkt_1_q <= cnt_pkt_1_q + 32'd1;
            else         cnt_pkt_0_q <= cnt_pkt_0_q + 32'd1;
            ifg_cnt_q <= IFG_LAST;
            state_q   <= IFG;
          end
        end

        DRAIN: begin
          tx_en_q <= 1'b0;
          tx_er_q <= 1'b0;
          if (!sel_empty && !sel_word[8]) begin
            ifg_cnt_q <= IFG_LAST;
            state_q   <= IFG;
          end
        end

        IFG: begin
          tx_en_q <= 1'b0;
          tx_er_q <= 1'b0;
          if (ifg_cnt_q == 8'd0) state_q   <= IDLE;
          else                   ifg_cnt_q <= ifg_cnt_q - 8'd1;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign gmii_txd     = txd_q;
  assign gmii_tx_en   = tx_en_q;
  assign gmii_tx_er   = tx_er_q;
  assign cnt_pkt_0    = cnt_pkt_0_q;
  assign cnt_pkt_1    = cnt_pkt_1_q;
  assign cnt_trunc    = cnt_trunc_q;
  assign cnt_underrun = cnt_underrun_q;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter: FWFT FIFO models feed two instances
// (default length limit and a 64-byte limit) and a GMII monitor collects frames.
module tb_gmii_tx_arbiter;

  localparam int IFG = 12;

  logic clk_125m = 1'b0;
  always #4 clk_125m = ~clk_125m;

  logic        rst;
  logic        tx_enable;
  logic        empty_w [4];
  logic [8:0]  dout_w  [4];
  logic        rden_w  [4];
  logic [7:0]  txd_w   [2];
  logic        txen_w  [2];
  logic        txer_w  [2];
  logic [31:0] pkt0_w  [2];
  logic [31:0] pkt1_w  [2];
  logic [15:0] trunc_w [2];
  logic [15:0] ur_w    [2];

  gmii_tx_arbiter #(.IFG_CYCLES(IFG), .MAX_PKT_LEN(1536)) u_dut (
    .clk_125m(clk_125m), .rst(rst), .tx_enable(tx_enable),
    .empty_0(empty_w[0]), .dout_0(dout_w[0]), .rden_0(rden_w[0]),
    .empty_1(empty_w[1]), .dout_1(dout_w[1]), .rden_1(rden_w[1]),
    .gmii_txd(txd_w[0]), .gmii_tx_en(txen_w[0]), .gmii_tx_er(txer_w[0]),
    .cnt_pkt_0(pkt0_w[0]), .cnt_pkt_1(pkt1_w[0]),
    .cnt_trunc(trunc_w[0]), .cnt_underrun(ur_w[0])
  );

  gmii_tx_arbiter #(.IFG_CYCLES(IFG), .MAX_PKT_LEN(64)) u_dut_trunc (
    .clk_125m(clk_125m), .rst(rst), .tx_enable(tx_enable),
    .empty_0(empty_w[2]), .dout_0(dout_w[2]), .rden_0(rden_w[2]),
    .empty_1(empty_w[3]), .dout_1(dout_w[3]), .rden_1(rden_w[3]),
    .gmii_txd(txd_w[1]), .gmii_tx_en(txen_w[1]), .gmii_tx_er(txer_w[1]),
    .cnt_pkt_0(pkt0_w[1]), .cnt_pkt_1(pkt1_w[1]),
    .cnt_trunc(trunc_w[1]), .cnt_underrun(ur_w[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO models: bit 9 marks a bubble word that shows as one empty cycle.
  logic [9:0] fq [4][$];
  int         popcnt [4] = '{0, 0, 0, 0};

  always @(posedge clk_125m) begin
    for (int f = 0; f < 4; f++) begin
      if (fq[f].size() > 0) begin
        if (fq[f][0][9]) begin
          void'(fq[f].pop_front());
        end else if (rden_w[f]) begin
          void'(fq[f].pop_front());
          popcnt[f] <= popcnt[f] + 1;
        end
      end
      if (fq[f].size() > 0) begin
        empty_w[f] <= fq[f][0][9];
        dout_w[f]  <= fq[f][0][8:0];
      end else begin
        empty_w[f] <= 1'b1;
        dout_w[f]  <= '0;
      end
    end
  end

  // GMII monitor, sampled on the falling edge.
  logic       mon_clr;
  int         in_frame [2];
  int         flen     [2];
  int         low      [2];
  int         seen     [2];
  int         urcnt    [2];
  int         urbad    [2];
  int         urpos    [2];
  int         encyc    [2];
  logic [7:0] rxq      [2][$];
  logic [7:0] firstq   [2][$];
  int         lenq     [2][$];
  int         gapq     [2][$];

  always @(negedge clk_125m) begin
    for (int i = 0; i < 2; i++) begin
      if (mon_clr) begin
        in_frame[i] <= 0;
        flen[i]     <= 0;
        low[i]      <= 0;
        seen[i]     <= 0;
        urcnt[i]    <= 0;
        urbad[i]    <= 0;
        urpos[i]    <= -1;
        encyc[i]    <= 0;
        rxq[i].delete();
        firstq[i].delete();
        lenq[i].delete();
        gapq[i].delete();
      end else if (txen_w[i]) begin
        encyc[i] <= encyc[i] + 1;
        if (in_frame[i] == 0) begin
          if (seen[i] != 0) gapq[i].push_back(low[i]);
          firstq[i].push_back(txd_w[i]);
          in_frame[i] <= 1;
          flen[i]     <= 1;
        end else begin
          flen[i] <= flen[i] + 1;
        end
        if (txer_w[i]) begin
          urcnt[i] <= urcnt[i] + 1;
          if (urcnt[i] == 0) urpos[i] <= (in_frame[i] != 0) ? flen[i] : 0;
          if (txd_w[i] != 8'h00) urbad[i] <= urbad[i] + 1;
        end else begin
          rxq[i].push_back(txd_w[i]);
        end
      end else begin
        if (in_frame[i] != 0) begin
          lenq[i].push_back(flen[i]);
          in_frame[i] <= 0;
          seen[i]     <= 1;
          low[i]      <= 1;
        end else begin
          low[i] <= low[i] + 1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_125m);
    #1;
  endtask

  task automatic push_data(input int f, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) fq[f].push_back({1'b0, 1'b1, base + 8'(k)});
  endtask

  task automatic push_delim(input int f);
    fq[f].push_back(10'h000);
  endtask

  task automatic push_pkt(input int f, input int n, input logic [7:0] base);
    push_data(f, n, base);
    push_delim(f);
  endtask

  task automatic push_bubbles(input int f, input int n);
    for (int k = 0; k < n; k++) fq[f].push_back(10'h200);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    for (int f = 0; f < 4; f++) fq[f].delete();
    mon_clr = 1'b1;
    tick(2);
    mon_clr = 1'b0;
    rst = 1'b0;
  endtask

  task automatic wait_frames(input int i, input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (lenq[i].size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, lenq[i].size(), n);
  endtask

  // Counts rising edges until tx_en is seen on the following falling edge.
  task automatic measure_latency(input int i, input int budget, output int lat);
    bit hit;
    hit = 1'b0;
    lat = 0;
    while (!hit && lat < budget) begin
      @(posedge clk_125m);
      lat++;
      @(negedge clk_125m);
      if (txen_w[i]) hit = 1'b1;
    end
    if (!hit) lat = -1;
  endtask

  int lat;
  int bad;
  int p0;
  int p1;
  int k;

  initial begin
    rst       = 1'b1;
    tx_enable = 1'b0;
    mon_clr   = 1'b0;
    do_reset();

    check_eq("rst_tx_en", txen_w[0], 0);
    check_eq("rst_tx_er", txer_w[0], 0);
    check_eq("rst_txd", txd_w[0], 0);
    check_eq("rst_cnt_sum", pkt0_w[0] | pkt1_w[0] | trunc_w[0] | ur_w[0], 0);

    // 1: single 64-byte packet on port 0
    tx_enable = 1'b1;
    push_pkt(0, 64, 8'h00);
    p0 = popcnt[0];
    measure_latency(0, 10, lat);
    check_eq("t1_latency", lat, 3);
    wait_frames(0, 1, 300, "t1_frames");
    check_eq("t1_len", lenq[0][0], 64);
    check_eq("t1_rx_size", rxq[0].size(), 64);
    bad = 0;
    for (int j = 0; j < 64; j++) if (rxq[0][j] !== 8'(j)) bad++;
    check_eq("t1_bytes_bad", bad, 0);
    check_eq("t1_cnt_pkt_0", pkt0_w[0], 1);
    check_eq("t1_cnt_pkt_1", pkt1_w[0], 0);
    tick(20);
    check_eq("t1_txen_cycles", encyc[0], 64);
    check_eq("t1_pops", popcnt[0] - p0, 65);

    // 2: three 60-byte packets on each port, alternating grants
    do_reset();
    for (int p = 0; p < 3; p++) begin
      push_pkt(0, 60, 8'h00);
      push_pkt(1, 60, 8'h80);
    end
    wait_frames(0, 6, 3000, "t2_frames");
    for (int j = 0; j < 6; j++) begin
      check_eq($sformatf("t2_first_%0d", j), firstq[0][j], (j % 2 == 1) ? 8'h80 : 8'h00);
      check_eq($sformatf("t2_len_%0d", j), lenq[0][j], 60);
    end
    check_eq("t2_gap_count", gapq[0].size(), 5);
    for (int j = 0; j < 5; j++)
      check_eq($sformatf("t2_gap_%0d", j), gapq[0][j], IFG + 2);
    check_eq("t2_cnt_pkt_0", pkt0_w[0], 3);
    check_eq("t2_cnt_pkt_1", pkt1_w[0], 3);

    // 3: truncation at 64 bytes on the limited instance, port 1
    do_reset();
    push_pkt(3, 100, 8'h80);
    push_pkt(3, 60, 8'h10);
    wait_frames(1, 2, 2000, "t3_frames");
    check_eq("t3_len_0", lenq[1][0], 64);
    check_eq("t3_len_1", lenq[1][1], 60);
    check_eq("t3_gap", gapq[1][0], 36 + 1 + IFG + 1);
    check_eq("t3_rx_size", rxq[1].size(), 124);
    bad = 0;
    for (int j = 0; j < 64; j++) if (rxq[1][j] !== 8'h80 + 8'(j)) bad++;
    for (int j = 0; j < 60; j++) if (rxq[1][64 + j] !== 8'h10 + 8'(j)) bad++;
    check_eq("t3_bytes_bad", bad, 0);
    check_eq("t3_cnt_trunc", trunc_w[1], 1);
    check_eq("t3_cnt_pkt_1", pkt1_w[1], 1);
    check_eq("t3_cnt_pkt_0", pkt0_w[1], 0);
    tick(20);
    check_eq("t3_fifo_drained", fq[3].size(), 0);

    // 4: three-cycle underrun after byte 10
    do_reset();
    push_data(0, 10, 8'h00);
    push_bubbles(0, 3);
    push_data(0, 50, 8'h0A);
    push_delim(0);
    wait_frames(0, 1, 500, "t4_frames");
    check_eq("t4_len", lenq[0][0], 63);
    check_eq("t4_ur_cycles", urcnt[0], 3);
    check_eq("t4_ur_txd_nonzero", urbad[0], 0);
    check_eq("t4_ur_pos", urpos[0], 10);
    check_eq("t4_rx_size", rxq[0].size(), 60);
    bad = 0;
    for (int j = 0; j < 60; j++) if (rxq[0][j] !== 8'(j)) bad++;
    check_eq("t4_bytes_bad", bad, 0);
    check_eq("t4_cnt_underrun", ur_w[0], 3);
    check_eq("t4_cnt_pkt_0", pkt0_w[0], 1);

    // 5: tx_enable gating
    do_reset();
    tx_enable = 1'b0;
    push_pkt(0, 60, 8'h00);
    push_pkt(1, 60, 8'h80);
    p0 = popcnt[0];
    p1 = popcnt[1];
    tick(100);
    check_eq("t5_pops_disabled", (popcnt[0] - p0) + (popcnt[1] - p1), 0);
    check_eq("t5_txen_disabled", encyc[0], 0);
    tx_enable = 1'b1;
    measure_latency(0, 10, lat);
    check_eq("t5_latency", lat, 2);
    tx_enable = 1'b0;
    wait_frames(0, 1, 300, "t5_frames");
    check_eq("t5_len", lenq[0][0], 60);
    check_eq("t5_first", firstq[0][0], 8'h00);
    tick(200);
    check_eq("t5_no_regrant", lenq[0].size(), 1);
    check_eq("t5_port1_untouched", fq[1].size(), 61);
    check_eq("t5_cnt_pkt_0", pkt0_w[0], 1);
    check_eq("t5_cnt_pkt_1", pkt1_w[0], 0);

    // 6: zero-length packet, then reset mid-packet
    do_reset();
    tx_enable = 1'b1;
    push_delim(0);
    push_pkt(0, 60, 8'h00);
    measure_latency(0, 40, lat);
    check_eq("t6_zero_len_latency", lat, 3 + IFG + 2);
    check_eq("t6_zero_len_counted", pkt0_w[0], 1);
    check_eq("t6_zero_len_no_frame", lenq[0].size(), 0);
    k = 0;
    while (!(txen_w[0] && txd_w[0] == 8'd20) && k < 100) begin
      @(negedge clk_125m);
      k++;
    end
    check_eq("t6_byte20_seen", (k < 100) ? 1 : 0, 1);
    rst = 1'b1;
    #1;
    check_eq("t6_rden0_in_rst", rden_w[0], 0);
    p0 = popcnt[0];
    @(posedge clk_125m);
    #1;
    check_eq("t6_txen_after_rst", txen_w[0], 0);
    check_eq("t6_cnt_pkt_0_after_rst", pkt0_w[0], 0);
    tick(2);
    check_eq("t6_no_pops_in_rst", popcnt[0] - p0, 0);
    check_eq("t6_fifo_kept", fq[0].size(), 40);
    check_eq("t6_rden_in_rst", {rden_w[0], rden_w[1]}, 0);
    for (int f = 0; f < 4; f++) fq[f].delete();
    mon_clr = 1'b1;
    push_pkt(1, 5, 8'hC0);
    push_pkt(0, 5, 8'h40);
    tick(2);
    mon_clr = 1'b0;
    rst = 1'b0;
    wait_frames(0, 2, 300, "t6_frames");
    check_eq("t6_first_grant", firstq[0][0], 8'h40);
    check_eq("t6_second_grant", firstq[0][1], 8'hC0);
    check_eq("t6_cnt_pkt_0", pkt0_w[0], 1);
    check_eq("t6_cnt_pkt_1", pkt1_w[0], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
